trace_frame_aligner: RTL and testbench

//  Parametrised TPIU frame aligner, single clock domain. Takes DDR trace samples already captured into clk.

---
 rtl/trace_pkg.sv | 21 ++
 rtl/trace_sync_detect.sv | 26 ++
 rtl/trace_frame_aligner.sv | 167 ++++++++++++++++
 tb/tb_trace_frame_aligner.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared TPIU constants, legal bus-width codes and the 8-halfword frame type.
package trace_pkg;

    localparam logic [31:0] TPIU_SYNC = 32'h7FFF_FFFF;
    localparam logic [15:0] TPIU_PASS = 16'h7FFF;
    localparam int unsigned FRAME_HW  = 8;

    typedef enum logic [3:0] {
        W1 = 4'd1,
        W2 = 4'd2,
        W4 = 4'd4,
        W8 = 4'd8
    } width_t;

    typedef logic [FRAME_HW-1:0][15:0] frame_t;

    function automatic logic width_legal(input logic [3:0] w, input int unsigned maxw);
        return ((w == W1) || (w == W2) || (w == W4) || (w == W8)) && (32'(w) <= maxw);
    endfunction

endpackage

// File: rtl/trace_sync_detect.sv
// Combinational search for the TPIU full sync at every bit phase of the newest sample.
module trace_sync_detect
    import trace_pkg::*;
#(
    parameter int unsigned HLEN = 39,
    parameter int unsigned MAXP = 8
) (
    input  logic [HLEN-1:0] hist,
    input  logic [4:0]      nbits,
    output logic            hit,
    output logic [3:0]      p
);

    // Ascending scan: the first match is the smallest phase offset.
    always_comb begin
        hit = 1'b0;
        p   = '0;
        for (int unsigned k = 0; k < MAXP; k++) begin
            if (!hit && (k < 32'(nbits)) && (hist[HLEN-1-k -: 32] == TPIU_SYNC)) begin
                hit = 1'b1;
                p   = 4'(k);
            end
        end
    end

endmodule

// File: rtl/trace_frame_aligner.sv
// TPIU frame aligner: bit-phase sync search, pass-halfword removal, 128-bit frame packing.
// Optional statistics ports are enabled by defining TRACE_FRAME_STATS_EN.
module trace_frame_aligner
    import trace_pkg::*;
#(
    parameter int unsigned MAXWIDTH     = 4,
    parameter int unsigned SYNC_TIMEOUT = 2**26-1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAXWIDTH-1:0] traceDina,
    input  logic [MAXWIDTH-1:0] traceDinb,
    input  logic                traceValid,
    input  logic [3:0]          width,
    output logic [127:0]        PacketOut,
    output logic                PackAvail,
    input  logic                PackAck,
    output logic                sync,
    output logic                overflow
`ifdef TRACE_FRAME_STATS_EN
    ,
    output logic [31:0]         frameCount,
    output logic [15:0]         dropCount,
    output logic [15:0]         resyncCount
`endif
);

    localparam int unsigned HLEN = 32 + 2*MAXWIDTH - 1;
    localparam int unsigned TW   = $clog2(SYNC_TIMEOUT + 1);

    logic [HLEN-1:0] hist, hist_nx;
    logic [3:0]      width_q;
    logic [4:0]      bitcnt, sum, residue, nbits;
    logic [2:0]      hwcnt;
    logic [TW-1:0]   timeout;
    frame_t          frame_acc, frame_nx;
    logic [7:0]      a8, b8;
    logic [15:0]     halfword;
    logic [3:0]      p;
    logic            legal, wchg, run, hit_raw, hit, aligned, extract, keep, done;

    assign a8      = 8'(traceDina);
    assign b8      = 8'(traceDinb);
    assign nbits   = {width, 1'b0};
    assign legal   = width_legal(width, MAXWIDTH);
    assign wchg    = (width != width_q);
    assign run     = traceValid && legal && !wchg;
    assign aligned = sync && (timeout != '0);

    // Newest stream bit lands at the MSB, so every window reads LSB-first upward.
    always_comb begin
        case (width)
            W1:      hist_nx = {b8[0],   a8[0],   hist[HLEN-1:2]};
            W2:      hist_nx = {b8[1:0], a8[1:0], hist[HLEN-1:4]};
            W4:      hist_nx = {b8[3:0], a8[3:0], hist[HLEN-1:8]};
            W8:      hist_nx = {b8,      a8,      hist[HLEN-1:16]};
            default: hist_nx = hist;
        endcase
    end

    trace_sync_detect #(
        .HLEN (HLEN),
        .MAXP (2*MAXWIDTH)
    ) u_sync_detect (
        .hist  (hist_nx),
        .nbits (nbits),
        .hit   (hit_raw),
        .p     (p)
    );

    assign hit      = run && hit_raw;
    assign sum      = bitcnt + nbits;
    assign residue  = sum - 5'd16;
    assign extract  = run && !hit && aligned && (sum >= 5'd16);
    assign halfword = hist_nx[HLEN-1-residue -: 16];
    assign keep     = extract && (halfword != TPIU_PASS);
    assign done     = keep && (hwcnt == 3'd7);

    always_comb begin
        frame_nx        = frame_acc;
        frame_nx[hwcnt] = halfword;
    end

    always_ff @(posedge clk) begin
        overflow <= 1'b0;
        if (rst) begin
            hist      <= '0;
            width_q   <= width;
            bitcnt    <= '0;
            hwcnt     <= '0;
            timeout   <= '0;
            frame_acc <= '0;
            sync      <= 1'b0;
            PacketOut <= '0;
            PackAvail <= 1'b0;
        end else begin
            width_q <= width;
            if (!legal || wchg) begin
                hist    <= '0;
                sync    <= 1'b0;
                timeout <= '0;
                hwcnt   <= '0;
                bitcnt  <= '0;
            end else begin
                if (run)
                    hist <= hist_nx;
                if (hit) begin
                    bitcnt  <= {1'b0, p};
                    hwcnt   <= '0;
                    timeout <= TW'(SYNC_TIMEOUT);
                    sync    <= 1'b1;
                end else begin
                    if (timeout == '0) begin
                        sync  <= 1'b0;
                        hwcnt <= '0;
                    end else begin
                        timeout <= timeout - TW'(1);
                    end
                    if (run && aligned) begin
                        if (extract) begin
                            bitcnt <= residue;
                            if (keep) begin
                                frame_acc[hwcnt] <= halfword;
                                hwcnt            <= hwcnt + 3'd1;
                            end
                        end else begin
                            bitcnt <= sum;
                        end
                    end
                end
            end

            // A completing frame may replace one being acknowledged in the same cycle.
            if (done) begin
                if (!PackAvail || PackAck) begin
                    PacketOut <= frame_nx;
                    PackAvail <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (PackAvail && PackAck) begin
                PackAvail <= 1'b0;
            end
        end
    end

`ifdef TRACE_FRAME_STATS_EN
    logic [3:0] phase_mask;
    assign phase_mask = 4'(nbits - 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            frameCount  <= '0;
            dropCount   <= '0;
            resyncCount <= '0;
        end else begin
            if (PackAvail && PackAck)
                frameCount <= frameCount + 32'd1;
            if (done && PackAvail && !PackAck && (dropCount != '1))
                dropCount <= dropCount + 16'd1;
            if (hit && (!sync || (p != (bitcnt[3:0] & phase_mask))) && (resyncCount != '1))
                resyncCount <= resyncCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trace_frame_aligner.sv
// Directed bench for trace_frame_aligner: sync phases, pass removal, backpressure, timeout, width/reset.
module tb_trace_frame_aligner;

    logic         clk;
    logic         rst;
    logic [3:0]   traceDina, traceDinb;
    logic         traceValid;
    logic [3:0]   width;
    logic         PackAck;
    logic [127:0] pkt_out, b_pkt_out;
    logic         pkt_avail, b_pkt_avail;
    logic         sync_o, b_sync_o;
    logic         ovf, b_ovf;
`ifdef TRACE_FRAME_STATS_EN
    logic [31:0]  fc, b_fc;
    logic [15:0]  dc, b_dc, rc, b_rc;
`endif

    int n_vec = 0;
    int n_err = 0;
    int ovf_pulses = 0;
    int ovf0;
    bit q[$];

    trace_frame_aligner #(
        .MAXWIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .traceDina  (traceDina),
        .traceDinb  (traceDinb),
        .traceValid (traceValid),
        .width      (width),
        .PacketOut  (pkt_out),
        .PackAvail  (pkt_avail),
        .PackAck    (PackAck),
        .sync       (sync_o),
        .overflow   (ovf)
`ifdef TRACE_FRAME_STATS_EN
        ,
        .frameCount  (fc),
        .dropCount   (dc),
        .resyncCount (rc)
`endif
    );

    trace_frame_aligner #(
        .MAXWIDTH     (4),
        .SYNC_TIMEOUT (16)
    ) dut_to (
        .clk        (clk),
        .rst        (rst),
        .traceDina  (traceDina),
        .traceDinb  (traceDinb),
        .traceValid (traceValid),
        .width      (width),
        .PacketOut  (b_pkt_out),
        .PackAvail  (b_pkt_avail),
        .PackAck    (PackAck),
        .sync       (b_sync_o),
        .overflow   (b_ovf)
`ifdef TRACE_FRAME_STATS_EN
        ,
        .frameCount  (b_fc),
        .dropCount   (b_dc),
        .resyncCount (b_rc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ovf) ovf_pulses <= ovf_pulses + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) q.push_back(v[i]);
    endfunction

    function automatic void push_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) push({16'h0, base + 16'(i)}, 16);
    endfunction

    function automatic logic [127:0] mkframe(input logic [15:0] base);
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = base + 16'(i);
        return f;
    endfunction

    function automatic bit pop_bit();
        if (q.size() == 0) return 1'b0;
        return q.pop_front();
    endfunction

    // Leaves the last sample driven; the caller decides what happens at the next edge.
    task automatic send(input int w);
        while (q.size() > 0) begin
            logic [3:0] a, b;
            a = '0;
            b = '0;
            for (int i = 0; i < w; i++) a[i] = pop_bit();
            for (int i = 0; i < w; i++) b[i] = pop_bit();
            @(negedge clk);
            traceDina  = a;
            traceDinb  = b;
            traceValid = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        traceValid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        traceValid = 1'b0;
        PackAck    = 1'b1;
        @(negedge clk);
        PackAck    = 1'b0;
    endtask

    task automatic set_width(input logic [3:0] w);
        @(negedge clk);
        width      = w;
        traceValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst        = 1'b1;
        traceValid = 1'b0;
        PackAck    = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        traceDina  = '0;
        traceDinb  = '0;
        traceValid = 1'b0;
        width      = 4'd4;
        PackAck    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pkt",   pkt_out,   128'h0);
        check("rst_avail", pkt_avail, 1'b0);
        check("rst_sync",  sync_o,    1'b0);
        check("rst_ovf",   ovf,       1'b0);
        rst = 1'b0;

        // 1: w=4, sync at p=0, halfwords 1..8
        push(32'h7FFF_FFFF, 32);
        push_frame(16'h0001);
        send(4);
        check("t1_avail_pre", pkt_avail, 1'b0);
        idle();
        check("t1_avail", pkt_avail, 1'b1);
        check("t1_frame", pkt_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("t1_sync",  sync_o, 1'b1);
        ack();
        check("t1_ack_clr", pkt_avail, 1'b0);

        // 2: w=1, sync one bit late (p=1), pass halfwords interleaved
        set_width(4'd1);
        check("t2_wchg_sync", sync_o, 1'b0);
        push(32'h0, 1);
        push(32'h7FFF_FFFF, 32);
        for (int k = 1; k <= 8; k++) begin
            push(32'(k), 16);
            if (k < 8) push(32'h7FFF, 16);
        end
        push(32'h0, 1);
        send(1);
        check("t2_avail_pre", pkt_avail, 1'b0);
        idle();
        check("t2_avail", pkt_avail, 1'b1);
        check("t2_frame", pkt_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("t2_sync",  sync_o, 1'b1);
        ack();

        // 3: backpressure, second frame dropped
        set_width(4'd4);
        push(32'h7FFF_FFFF, 32);
        push_frame(16'h0011);
        push_frame(16'h0021);
        ovf0 = ovf_pulses;
        send(4);
        idle();
        check("t3_ovf_pulse", ovf, 1'b1);
        check("t3_avail", pkt_avail, 1'b1);
        check("t3_frame_held", pkt_out, mkframe(16'h0011));
        @(negedge clk);
        check("t3_ovf_end", ovf, 1'b0);
        repeat (2) @(negedge clk);
        check("t3_ovf_count", 128'(ovf_pulses - ovf0), 128'd1);
`ifdef TRACE_FRAME_STATS_EN
        check("t3_dropcount", dc, 16'd1);
`endif

        // 4: frame completes in the ack cycle
        ovf0 = ovf_pulses;
        push_frame(16'h0031);
        send(4);
        PackAck = 1'b1;
        idle();
        PackAck = 1'b0;
        check("t4_avail", pkt_avail, 1'b1);
        check("t4_frame", pkt_out, mkframe(16'h0031));
        check("t4_ovf",   ovf, 1'b0);
        @(negedge clk);
        check("t4_avail_hold", pkt_avail, 1'b1);
        check("t4_ovf_count", 128'(ovf_pulses - ovf0), 128'd0);

        // 5: timeout of 16 on the second instance
        pulse_rst();
        check("t5_rst_avail", b_pkt_avail, 1'b0);
        push(32'h7FFF_FFFF, 32);
        push_frame(16'h0041);
        send(4);
        idle();
        check("t5_sync_16",  b_sync_o, 1'b1);
        check("t5_avail",    b_pkt_avail, 1'b1);
        check("t5_frame",    b_pkt_out, mkframe(16'h0041));
        @(negedge clk);
        check("t5_sync_17",  b_sync_o, 1'b0);
        check("t5_avail_17", b_pkt_avail, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_frame_kept", b_pkt_out, mkframe(16'h0041));
        check("t5_avail_kept", b_pkt_avail, 1'b1);
        check("t5_long_sync",  sync_o, 1'b1);

        // 6: width change mid-frame, then reset mid-frame
        ack();
        push(32'h7FFF_FFFF, 32);
        for (int k = 0; k < 4; k++) push(32'h51 + 32'(k), 16);
        send(4);
        idle();
        check("t6_sync", sync_o, 1'b1);
        @(negedge clk);
        width      = 4'd2;
        traceDina  = 4'hF;
        traceDinb  = 4'hF;
        traceValid = 1'b1;
        @(negedge clk);
        traceValid = 1'b0;
        check("t6_wchg_sync", sync_o, 1'b0);
        for (int k = 0; k < 4; k++) push(32'h55 + 32'(k), 16);
        send(2);
        idle();
        check("t6_no_frame", pkt_avail, 1'b0);
        push(32'h7FFF_FFFF, 32);
        push(32'h61, 16);
        push(32'h62, 16);
        send(2);
        idle();
        check("t6_resync", sync_o, 1'b1);
        pulse_rst();
        check("t6_rst_pkt",   pkt_out,   128'h0);
        check("t6_rst_avail", pkt_avail, 1'b0);
        check("t6_rst_sync",  sync_o,    1'b0);
        check("t6_rst_ovf",   ovf,       1'b0);
        for (int k = 0; k < 6; k++) push(32'h63 + 32'(k), 16);
        send(2);
        idle();
        check("t6_post_rst_avail", pkt_avail, 1'b0);
        check("t6_post_rst_sync",  sync_o,    1'b0);

        // 7: illegal widths drop sync
        push(32'h7FFF_FFFF, 32);
        send(2);
        idle();
        check("t7_sync_w2", sync_o, 1'b1);
        set_width(4'd3);
        check("t7_w3_sync", sync_o, 1'b0);
        set_width(4'd2);
        push(32'h7FFF_FFFF, 32);
        send(2);
        idle();
        check("t7_sync_again", sync_o, 1'b1);
        set_width(4'd8);
        check("t7_w8_sync", sync_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
